// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, absorbs imem
// wait states through a one-entry holding buffer and loads the IF/ID register.
// Optional build macro: ALIGN_CHECK_EN adds misaligned-fetch detection, the
// EXC_VECTOR parameter and the D_ExcAdEL output.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        Stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] F_PC,
  output logic [31:0] F_PCplus4,
  output logic        F_Busy,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PCplus4,
  output logic        D_Valid
`ifdef ALIGN_CHECK_EN
  ,
  output logic        D_ExcAdEL
`endif
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] next_pc;
  logic        misalign;
  logic        avail;
  logic        advance;
  logic        capture;

  assign pc_plus4 = pc + 32'd4;

`ifdef ALIGN_CHECK_EN
  // A misaligned PC never reaches imem; it resolves locally as an exception.
  assign misalign = (state == S_REQ) && (pc[1:0] != 2'b00);
  assign next_pc  = misalign ? EXC_VECTOR : NPC;
`else
  assign misalign = 1'b0;
  assign next_pc  = NPC;
`endif

  assign avail   = (state == S_HOLD) || (imem_ready || misalign);
  assign advance = avail && !Stall;
  // imem delivered while D is frozen: park the word so the request can drop.
  assign capture = (state == S_REQ) && imem_ready && Stall && !misalign;
  assign instr   = misalign ? 32'h0 : ((state == S_HOLD) ? buf_instr : imem_rdata);

  assign imem_req  = !reset && (state == S_REQ) && !misalign;
  assign imem_addr = {pc[31:2], 2'b00};
  assign F_PC      = pc;
  assign F_PCplus4 = pc_plus4;
  assign F_Busy    = (state == S_REQ) && !imem_ready && !misalign;

  // ---- F -> D boundary: PC, fetch state and IF/ID register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      D_Instr   <= 32'h0;
      D_PCplus4 <= 32'h0;
      D_Valid   <= 1'b0;
`ifdef ALIGN_CHECK_EN
      D_ExcAdEL <= 1'b0;
`endif
    end else if (advance) begin
      state     <= S_REQ;
      pc        <= next_pc;
      D_Instr   <= instr;
      D_PCplus4 <= pc_plus4;
      D_Valid   <= 1'b1;
`ifdef ALIGN_CHECK_EN
      D_ExcAdEL <= misalign;
`endif
    end else if (capture) begin
      state <= S_HOLD;
    end
  end

  // Holding buffer is pure data; its validity is carried by state == S_HOLD.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      buf_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a reference model predicts the
// combinational fetch outputs each cycle and pushes the expected IF/ID
// contents to a scoreboard queue that is popped after the clock edge.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        imem_ready;
  logic [31:0] NPC;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] F_PC;
  logic [31:0] F_PCplus4;
  logic        F_Busy;
  logic [31:0] D_Instr;
  logic [31:0] D_PCplus4;
  logic        D_Valid;
  logic        D_ExcAdEL;

  logic        npc_follow;
  logic [31:0] npc_fixed;
  logic        ovr_en;
  logic [31:0] ovr_val;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        exc;
  } d_exp_t;

  d_exp_t      sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_buf;
  logic        m_hold;
  d_exp_t      m_d;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  assign NPC        = npc_follow ? F_PCplus4 : npc_fixed;
  assign imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);

  if_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .NPC        (NPC),
    .Stall      (Stall),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .F_PC       (F_PC),
    .F_PCplus4  (F_PCplus4),
    .F_Busy     (F_Busy),
    .D_Instr    (D_Instr),
    .D_PCplus4  (D_PCplus4),
`ifdef ALIGN_CHECK_EN
    .D_Valid    (D_Valid),
    .D_ExcAdEL  (D_ExcAdEL)
`else
    .D_Valid    (D_Valid)
`endif
  );

`ifndef ALIGN_CHECK_EN
  assign D_ExcAdEL = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check fetch outputs mid-cycle, advance model,
  // then pop and check IF/ID after the edge. Entered at posedge+1.
  task automatic cyc(input logic st, input logic rd, input logic rs);
    logic        mis;
    logic [31:0] npc_v;
    logic [31:0] rdata_v;
    d_exp_t      e;
    Stall      = st;
    imem_ready = rd;
    reset      = rs;
    @(negedge clk);
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = !m_hold && (m_pc[1:0] != 2'b00);
`endif
    rdata_v = ovr_en ? ovr_val : mem_word({m_pc[31:2], 2'b00});
    npc_v   = npc_follow ? (m_pc + 32'd4) : npc_fixed;
    check_val("imem_req", imem_req, !rs && !m_hold && !mis);
    check_val("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
    check_val("F_PC", F_PC, m_pc);
    check_val("F_PCplus4", F_PCplus4, m_pc + 32'd4);
    check_val("F_Busy", F_Busy, !m_hold && !rd && !mis);
    if (rs) begin
      m_pc   = RST_PC;
      m_hold = 1'b0;
      m_d    = '0;
    end else if ((m_hold || rd || mis) && !st) begin
      m_d.instr = mis ? 32'h0 : (m_hold ? m_buf : rdata_v);
      m_d.pc4   = m_pc + 32'd4;
      m_d.valid = 1'b1;
      m_d.exc   = mis;
      m_pc      = mis ? EXC_PC : npc_v;
      m_hold    = 1'b0;
    end else if (!m_hold && rd && st && !mis) begin
      m_buf  = rdata_v;
      m_hold = 1'b1;
    end
    sb.push_back(m_d);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("D_Instr", D_Instr, e.instr);
    check_val("D_PCplus4", D_PCplus4, e.pc4);
    check_val("D_Valid", D_Valid, e.valid);
    check_val("D_ExcAdEL", D_ExcAdEL, e.exc);
  endtask

  initial begin
    logic [31:0] r;
    reset      = 1'b1;
    Stall      = 1'b0;
    imem_ready = 1'b0;
    npc_follow = 1'b1;
    npc_fixed  = 32'h0;
    ovr_en     = 1'b0;
    ovr_val    = 32'h0;
    @(posedge clk);
    #1;
    m_pc   = RST_PC;
    m_hold = 1'b0;
    m_buf  = 32'h0;
    m_d    = '0;

    // reset state
    cyc(1'b0, 1'b1, 1'b1);
    check_val("rst_pc", F_PC, 32'h0000_3000);
    check_val("rst_dvalid", D_Valid, 32'h0);
    check_val("rst_dinstr", D_Instr, 32'h0);

    // zero-latency fetch with ready high
    cyc(1'b0, 1'b1, 1'b0);
    check_val("t1_pc", F_PC, 32'h0000_3004);
    check_val("t1_dpc4", D_PCplus4, 32'h0000_3004);
    check_val("t1_dinstr", D_Instr, mem_word(32'h0000_3000));
    check_val("t1_dvalid", D_Valid, 32'h1);

    // three wait cycles at 3004, then advance
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check_val("wait_pc", F_PC, 32'h0000_3004);
      check_val("wait_dpc4", D_PCplus4, 32'h0000_3004);
    end
    cyc(1'b0, 1'b1, 1'b0);
    check_val("wait_adv_dpc4", D_PCplus4, 32'h0000_3008);
    check_val("wait_adv_pc", F_PC, 32'h0000_3008);

    // branch redirect held through two wait cycles on delay-slot fetch
    npc_follow = 1'b0;
    npc_fixed  = 32'h0000_3100;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_val("br_dpc4", D_PCplus4, 32'h0000_300C);
    check_val("br_pc", F_PC, 32'h0000_3100);
    npc_follow = 1'b1;

    // stall with ready: buffered word survives rdata change
    ovr_en  = 1'b1;
    ovr_val = 32'hAAAA_0001;
    cyc(1'b1, 1'b1, 1'b0);
    ovr_val = 32'hBBBB_0002;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_val("hold_dinstr", D_Instr, 32'hAAAA_0001);
    check_val("hold_dpc4", D_PCplus4, 32'h0000_3104);
    ovr_en = 1'b0;

    // reset while in HOLD
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check_val("rhold_pc", F_PC, 32'h0000_3000);
    check_val("rhold_dvalid", D_Valid, 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_val("rhold_dinstr", D_Instr, mem_word(32'h0000_3000));

    // reset while waiting
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check_val("rwait_pc", F_PC, 32'h0000_3000);
    cyc(1'b0, 1'b1, 1'b0);
    check_val("rwait_dpc4", D_PCplus4, 32'h0000_3004);

    // PC wrap
    npc_follow = 1'b0;
    npc_fixed  = 32'hFFFF_FFFC;
    cyc(1'b0, 1'b1, 1'b0);
    npc_follow = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    check_val("wrap_pc", F_PC, 32'h0);
    check_val("wrap_dpc4", D_PCplus4, 32'h0);

    // misaligned NPC
    cyc(1'b0, 1'b1, 1'b1);
    npc_follow = 1'b0;
    npc_fixed  = 32'h0000_3002;
    cyc(1'b0, 1'b1, 1'b0);
    check_val("mis_pc", F_PC, 32'h0000_3002);
    npc_follow = 1'b1;
`ifdef ALIGN_CHECK_EN
    cyc(1'b0, 1'b0, 1'b0);
    check_val("mis_exc", D_ExcAdEL, 32'h1);
    check_val("mis_dinstr", D_Instr, 32'h0);
    check_val("mis_dpc4", D_PCplus4, 32'h0000_3006);
    check_val("mis_vec", F_PC, 32'h0000_4180);
`else
    cyc(1'b0, 1'b1, 1'b0);
    check_val("mis_dinstr", D_Instr, mem_word(32'h0000_3000));
    check_val("mis_dpc4", D_PCplus4, 32'h0000_3006);
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      r          = $urandom;
      npc_follow = ($urandom_range(0, 4) != 0);
      npc_fixed  = {r[31:2], 2'b00};
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
